// File: rtl/regfile_sb.sv
// Register file with per-entry busy (scoreboard) bits, optional write-to-read
// forwarding and a sequential clear sequence that walks every entry once.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic              clear_req,
    output logic              clr_busy
);

    localparam int                NREGS    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
    localparam bit                ZERO_EN  = bit'(ZERO_REG);
    localparam bit                BYP_EN   = bit'(BYPASS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [DATA_W-1:0]   mem_r [NREGS];
    logic [NREGS-1:0]    busy_r;
    logic                clr_busy_r;
    logic                wr_ok_s;
    logic                iss_ok_s;

    // Next-state logic for the idle/clear sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) state_s = ST_CLEAR;
                else           state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (cnt_r == LAST_IDX) state_s = ST_IDLE;
                else                   state_s = ST_CLEAR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Qualify writeback and issue: only in IDLE, never to a hardwired zero entry
    always_comb begin
        wr_ok_s  = we && (state_r == ST_IDLE) && !(ZERO_EN && (waddr == ZERO_IDX));
        iss_ok_s = iss_valid && (state_r == ST_IDLE) && !(ZERO_EN && (iss_dest == ZERO_IDX));
    end

    // State, clear index, data array and busy vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= ZERO_IDX;
            busy_r     <= {NREGS{1'b0}};
            clr_busy_r <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_r    <= state_s;
            clr_busy_r <= (state_s == ST_CLEAR);
            if (state_r == ST_CLEAR) begin
                mem_r[cnt_r]  <= {DATA_W{1'b0}};
                busy_r[cnt_r] <= 1'b0;
                cnt_r         <= cnt_r + ONE_IDX;
            end else begin
                cnt_r <= ZERO_IDX;
                if (wr_ok_s) begin
                    mem_r[waddr]  <= wdata;
                    busy_r[waddr] <= 1'b0;
                end
                // Issue after writeback so a same-edge new producer keeps the entry busy
                if (iss_ok_s) begin
                    busy_r[iss_dest] <= 1'b1;
                end
            end
        end
    end

    assign clr_busy = clr_busy_r;

    // rs read port with optional forwarding of the in-flight writeback
    always_comb begin
        if (BYP_EN && wr_ok_s && (waddr == rs_addr)) begin
            rs_data = wdata;
            rs_busy = 1'b0;
        end else if (ZERO_EN && (rs_addr == ZERO_IDX)) begin
            rs_data = {DATA_W{1'b0}};
            rs_busy = 1'b0;
        end else begin
            rs_data = mem_r[rs_addr];
            rs_busy = busy_r[rs_addr];
        end
    end

    // rt read port, identical to rs
    always_comb begin
        if (BYP_EN && wr_ok_s && (waddr == rt_addr)) begin
            rt_data = wdata;
            rt_busy = 1'b0;
        end else if (ZERO_EN && (rt_addr == ZERO_IDX)) begin
            rt_data = {DATA_W{1'b0}};
            rt_busy = 1'b0;
        end else begin
            rt_data = mem_r[rt_addr];
            rt_busy = busy_r[rt_addr];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding instance and a non-forwarding instance
// share stimulus and are compared against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, waddr, iss_dest;
    logic [31:0] wdata;
    logic        we, iss_valid, clear_req;
    logic [31:0] rs_data, rt_data, nb_rs_data, nb_rt_data;
    logic        rs_busy, rt_busy, nb_rs_busy, nb_rt_busy, clr_busy, nb_clr_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_clr;
    int          m_cidx;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_dest(iss_dest), .clear_req(clear_req), .clr_busy(clr_busy)
    );

    regfile_sb #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(nb_rs_data), .rt_data(nb_rt_data), .rs_busy(nb_rs_busy), .rt_busy(nb_rt_busy),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_dest(iss_dest), .clear_req(clear_req), .clr_busy(nb_clr_busy)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_clr  = 1'b0;
        m_cidx = 0;
    endtask

    function automatic bit fwd_hit(input logic [4:0] a, input bit byp);
        return byp && we && !m_clr && (a == waddr) && (a != 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (fwd_hit(a, byp)) return wdata;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (fwd_hit(a, byp)) return 1'b0;
        return m_busy[a];
    endfunction

    // Advance one clock edge and apply the same edge to the model
    task automatic tick();
        @(posedge clk);
        if (m_clr) begin
            m_mem[m_cidx]  = 32'h0;
            m_busy[m_cidx] = 1'b0;
            m_cidx++;
            if (m_cidx == 32) m_clr = 1'b0;
        end else begin
            if (we && waddr != 5'd0) begin
                m_mem[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (iss_valid && iss_dest != 5'd0) m_busy[iss_dest] = 1'b1;
            if (clear_req) begin
                m_clr  = 1'b1;
                m_cidx = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; iss_valid = 1'b0; clear_req = 1'b0;
        waddr = 5'd0; wdata = 32'h0; iss_dest = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int n = 0; n < 8; n++) begin
            rs_addr = 5'($urandom); rt_addr = 5'($urandom);
            #1;
            checks++;
            if ({rs_data, rt_data, nb_rs_data, nb_rt_data} !== 128'h0) begin
                errors++; $display("FAIL reset_data: got %h %h expected 0", rs_data, rt_data);
            end
            checks++;
            if ({rs_busy, rt_busy, nb_rs_busy, nb_rt_busy, clr_busy} !== 5'b0) begin
                errors++; $display("FAIL reset_busy: got %b%b clr %b expected 0", rs_busy, rt_busy, clr_busy);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; rs_addr = 5'd1; rt_addr = 5'd2;
        tick();
        idle_inputs(); rs_addr = 5'd5;
        #1;
        checks++;
        if (rs_data !== 32'hDEADBEEF || nb_rs_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_read_data: got %h/%h expected deadbeef", rs_data, nb_rs_data);
        end
        checks++;
        if (rs_busy !== 1'b0) begin
            errors++; $display("FAIL write_read_busy: got %b expected 0", rs_busy);
        end
        tick();
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; rt_addr = 5'd7; rs_addr = 5'd5;
        #1;
        checks++;
        if (rt_data !== 32'h12345678 || rt_busy !== 1'b0) begin
            errors++; $display("FAIL bypass_fwd: got %h busy %b expected 12345678 busy 0", rt_data, rt_busy);
        end
        checks++;
        if (nb_rt_data !== 32'h0) begin
            errors++; $display("FAIL bypass_off_old: got %h expected 00000000", nb_rt_data);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (nb_rt_data !== 32'h12345678) begin
            errors++; $display("FAIL bypass_off_after: got %h expected 12345678", nb_rt_data);
        end
        tick();
    endtask

    task automatic test_busy();
        idle_inputs();
        iss_valid = 1'b1; iss_dest = 5'd3;
        tick();
        idle_inputs(); rs_addr = 5'd3; rt_addr = 5'd3;
        #1;
        checks++;
        if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin
            errors++; $display("FAIL busy_set: got %b/%b expected 1", rs_busy, rt_busy);
        end
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5;
        #1;
        checks++;
        if (rs_busy !== 1'b0 || rs_data !== 32'hA5 || nb_rs_busy !== 1'b1) begin
            errors++; $display("FAIL busy_wb_fwd: got %b %h nb %b expected 0 a5 nb 1", rs_busy, rs_data, nb_rs_busy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs_busy !== 1'b0 || rs_data !== 32'hA5) begin
            errors++; $display("FAIL busy_cleared: got %b %h expected 0 a5", rs_busy, rs_data);
        end
        we = 1'b1; waddr = 5'd3; wdata = 32'h5A; iss_valid = 1'b1; iss_dest = 5'd3;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rs_busy !== 1'b1 || rs_data !== 32'h5A) begin
            errors++; $display("FAIL busy_new_producer: got %b %h expected 1 5a", rs_busy, rs_data);
        end
        tick();
    endtask

    task automatic test_zero();
        idle_inputs();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; iss_valid = 1'b1; iss_dest = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rs_busy !== 1'b0) begin
            errors++; $display("FAIL zero_same_cycle: got %h busy %b expected 0", rs_data, rs_busy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({rs_data, nb_rt_data} !== 64'h0 || {rs_busy, nb_rt_busy} !== 2'b0) begin
            errors++; $display("FAIL zero_after: got %h %h busy %b%b expected 0", rs_data, nb_rt_data, rs_busy, nb_rt_busy);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we        = ($urandom_range(0, 1) == 1);
            waddr     = 5'($urandom);
            wdata     = $urandom;
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_dest  = 5'($urandom);
            clear_req = ($urandom_range(0, 149) == 0);
            rs_addr   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            rt_addr   = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom);
            #1;
            checks++;
            if (rs_data !== exp_data(rs_addr, 1'b1)) begin
                errors++; $display("FAIL rand_rs_data: got %h expected %h addr %0d", rs_data, exp_data(rs_addr, 1'b1), rs_addr);
            end
            checks++;
            if (rt_data !== exp_data(rt_addr, 1'b1)) begin
                errors++; $display("FAIL rand_rt_data: got %h expected %h addr %0d", rt_data, exp_data(rt_addr, 1'b1), rt_addr);
            end
            checks++;
            if ({rs_busy, rt_busy} !== {exp_busy(rs_addr, 1'b1), exp_busy(rt_addr, 1'b1)}) begin
                errors++; $display("FAIL rand_busy: got %b%b expected %b%b", rs_busy, rt_busy, exp_busy(rs_addr, 1'b1), exp_busy(rt_addr, 1'b1));
            end
            checks++;
            if ({nb_rs_data, nb_rt_data} !== {exp_data(rs_addr, 1'b0), exp_data(rt_addr, 1'b0)}) begin
                errors++; $display("FAIL rand_nb_data: got %h %h expected %h %h", nb_rs_data, nb_rt_data, exp_data(rs_addr, 1'b0), exp_data(rt_addr, 1'b0));
            end
            checks++;
            if ({nb_rs_busy, nb_rt_busy, clr_busy, nb_clr_busy} !== {exp_busy(rs_addr, 1'b0), exp_busy(rt_addr, 1'b0), m_clr, m_clr}) begin
                errors++; $display("FAIL rand_nb_busy_clr: got %b%b clr %b%b expected %b%b clr %b", nb_rs_busy, nb_rt_busy, clr_busy, nb_clr_busy, exp_busy(rs_addr, 1'b0), exp_busy(rt_addr, 1'b0), m_clr);
            end
            tick();
        end
        idle_inputs();
        while (m_clr) tick();
    endtask

    task automatic fill_all();
        for (int a = 0; a < 32; a++) begin
            we = 1'b1; waddr = 5'(a); wdata = $urandom | 32'h1;
            iss_valid = 1'b1; iss_dest = 5'(a + 3);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int n;
        fill_all();
        we = 1'b1; waddr = 5'd12; wdata = 32'h77; iss_valid = 1'b1; iss_dest = 5'd13; clear_req = 1'b1;
        tick();
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            we = 1'b1; waddr = 5'($urandom); wdata = $urandom | 32'h1;
            iss_valid = 1'b1; iss_dest = 5'($urandom); clear_req = ($urandom_range(0, 1) == 1);
            rs_addr = 5'($urandom); rt_addr = waddr;
            #1;
            checks++;
            if ({rs_data, rt_data, rs_busy, rt_busy} !== {exp_data(rs_addr, 1'b1), exp_data(rt_addr, 1'b1), exp_busy(rs_addr, 1'b1), exp_busy(rt_addr, 1'b1)}) begin
                errors++; $display("FAIL clear_partial: got %h %h %b%b expected %h %h %b%b", rs_data, rt_data, rs_busy, rt_busy, exp_data(rs_addr, 1'b1), exp_data(rt_addr, 1'b1), exp_busy(rs_addr, 1'b1), exp_busy(rt_addr, 1'b1));
            end
            tick();
            n++;
        end
        idle_inputs();
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL clear_duration: got %0d cycles expected 32", n);
        end
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(31 - a);
            #1;
            checks++;
            if ({rs_data, rt_data} !== 64'h0 || {rs_busy, rt_busy, clr_busy} !== 3'b0) begin
                errors++; $display("FAIL clear_result: addr %0d got %h %h busy %b%b clr %b expected 0", a, rs_data, rt_data, rs_busy, rt_busy, clr_busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_all();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        rs_addr = 5'd20; rt_addr = 5'd31;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0 || nb_clr_busy !== 1'b0) begin
            errors++; $display("FAIL midclear_clr_busy: got %b/%b expected 0", clr_busy, nb_clr_busy);
        end
        checks++;
        if ({rs_data, rt_data} !== 64'h0) begin
            errors++; $display("FAIL midclear_async_data: got %h %h expected 0", rs_data, rt_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(a);
            #1;
            checks++;
            if ({rs_data, nb_rt_data} !== 64'h0 || {rs_busy, clr_busy} !== 2'b0) begin
                errors++; $display("FAIL midclear_after: addr %0d got %h %h busy %b clr %b expected 0", a, rs_data, nb_rt_data, rs_busy, clr_busy);
            end
            tick();
        end
        we = 1'b1; waddr = 5'd9; wdata = 32'h0BADF00D;
        tick();
        idle_inputs(); rs_addr = 5'd9;
        #1;
        checks++;
        if (rs_data !== 32'h0BADF00D) begin
            errors++; $display("FAIL midclear_new_write: got %h expected 0badf00d", rs_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] written [32];
        logic [4:0]  prev;
        prev = 5'd1;
        for (int i = 1; i < 24; i++) begin
            we = 1'b1; waddr = 5'(i + 1); wdata = $urandom; iss_valid = 1'b0; clear_req = 1'b0;
            written[waddr] = wdata;
            rs_addr = prev; rt_addr = waddr;
            #1;
            if (i > 1) begin
                checks++;
                if (rs_data !== written[prev] || rs_data !== exp_data(prev, 1'b1)) begin
                    errors++; $display("FAIL b2b_prev: addr %0d got %h expected %h", prev, rs_data, written[prev]);
                end
            end
            checks++;
            if (rt_data !== wdata || nb_rt_data !== exp_data(waddr, 1'b0)) begin
                errors++; $display("FAIL b2b_fwd: got %h nb %h expected %h nb %h", rt_data, nb_rt_data, wdata, exp_data(waddr, 1'b0));
            end
            prev = waddr;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_busy();
        test_zero();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
